// File: rtl/fc_tile_engine_pkg.sv
// Shared types, helpers and derived constants for the fully-connected tile engine.
// - clog2: minimum-one address width helper
// - num_beats / num_tiles: derived counts for any parameter set
// - NB, NT, SH, NB_W, NT_W: values for the default 64-in / 10-out configuration
// - state_e: engine FSM states
package fc_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StComp, StDrain, StOut} state_e;

  // Width needed to index `value` entries; never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  function automatic int unsigned num_beats(input int unsigned c_in, input int unsigned cpf);
    return c_in / cpf;
  endfunction

  function automatic int unsigned num_tiles(input int unsigned k_out, input int unsigned kpf);
    return (k_out + kpf - 1) / kpf;
  endfunction

  localparam int unsigned NB   = num_beats(64, 4);
  localparam int unsigned NT   = num_tiles(10, 2);
  localparam int unsigned SH   = 6 + 13 - 6;
  localparam int unsigned NB_W = clog2(NB);
  localparam int unsigned NT_W = clog2(NT);

endpackage

// File: rtl/fc_tile_engine_if.sv
// Stream bundle for the tile engine: input blob stream, weight/bias stream, output blob
// stream and the sticky protocol error flag.
// - slave:  engine side (consumes blob_din / w_din, produces blob_dout / err)
// - master: environment side
interface fc_tile_engine_if #(
  parameter int unsigned CPF     = 4,
  parameter int unsigned KPF     = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned WW      = 16,
  parameter int unsigned BIAS_DW = 16
);
  logic [CPF*DW-1:0]      blob_din;
  logic                   blob_din_en;
  logic                   blob_din_eop;
  logic                   blob_din_rdy;
  logic [KPF*CPF*WW-1:0]  w_din;
  logic                   w_din_en;
  logic                   w_din_rdy;
  logic [KPF*BIAS_DW-1:0] bias_din;
  logic [KPF*DW-1:0]      blob_dout;
  logic                   blob_dout_en;
  logic                   blob_dout_eop;
  logic                   blob_dout_rdy;
  logic                   err;

  modport slave (
    input  blob_din, blob_din_en, blob_din_eop, w_din, w_din_en, bias_din, blob_dout_rdy,
    output blob_din_rdy, w_din_rdy, blob_dout, blob_dout_en, blob_dout_eop, err
  );

  modport master (
    output blob_din, blob_din_en, blob_din_eop, w_din, w_din_en, bias_din, blob_dout_rdy,
    input  blob_din_rdy, w_din_rdy, blob_dout, blob_dout_en, blob_dout_eop, err
  );
endinterface

// File: rtl/fc_tile_engine_postproc.sv
// Per-lane post-processing, purely combinational.
// - acc_i: signed accumulator (DIN_Q+W_Q fraction bits)
// - res_o: signed DW-bit result, rounded half-up by SH bits, saturated, optional ReLU
module fc_postproc #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned DW    = 16,
  parameter int unsigned SH    = 13,
  parameter int unsigned RELU  = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [DW-1:0]    res_o
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] Half = (ACC_W+1)'(1) << (SH - 1);
  localparam logic signed [ACC_W:0] MaxV = {{(ACC_W-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MinV = {{(ACC_W-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    biased  = signed'({acc_i[ACC_W-1], acc_i}) + Half;
    shifted = biased >>> SH;
    if (shifted > MaxV) begin
      res_o = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < MinV) begin
      res_o = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res_o = shifted[DW-1:0];
    end
    if (RELU != 0 && res_o[DW-1]) begin
      res_o = '0;
    end
  end
endmodule

// File: rtl/fc_tile_engine.sv
// Fully-connected tile engine. Buffers one C_IN input vector (NB beats of CPF channels),
// then for each of NT output tiles streams NB weight beats, computing KPF dot products
// with bias, rounding, saturation and optional ReLU.
// - clk, rst: clock, synchronous active-high reset
// - bus: input blob stream, weight/bias stream, output blob stream, sticky err
module fc_tile_engine
  import fc_pkg::*;
#(
  parameter int unsigned C_IN    = 64,
  parameter int unsigned K_OUT   = 10,
  parameter int unsigned CPF     = 4,
  parameter int unsigned KPF     = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned WW      = 16,
  parameter int unsigned BIAS_DW = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned DIN_Q   = 6,
  parameter int unsigned W_Q     = 13,
  parameter int unsigned BIAS_Q  = 6,
  parameter int unsigned DOUT_Q  = 6,
  parameter int unsigned RELU    = 0
) (
  input logic             clk,
  input logic             rst,
  fc_tile_engine_if.slave bus
);
  localparam int unsigned NumBeats  = num_beats(C_IN, CPF);
  localparam int unsigned NumTiles  = num_tiles(K_OUT, KPF);
  localparam int unsigned OutShift  = DIN_Q + W_Q - DOUT_Q;
  localparam int unsigned BiasShift = DIN_Q + W_Q - BIAS_Q;
  localparam int unsigned BeatW     = clog2(NumBeats);
  localparam int unsigned TileW     = clog2(NumTiles);

  if (C_IN % CPF != 0) begin : g_bad_cin
    $error("C_IN must be a multiple of CPF");
  end
  if (DIN_Q + W_Q < BIAS_Q) begin : g_bad_bias_q
    $error("DIN_Q + W_Q must be >= BIAS_Q");
  end
  if (DIN_Q + W_Q <= DOUT_Q) begin : g_bad_dout_q
    $error("DIN_Q + W_Q must be > DOUT_Q");
  end

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [TileW-1:0]   tile_q, tile_d;
  logic [1:0]         drain_q;
  logic               err_q;
  logic               blob_rdy, w_rdy, load_out;
  logic               blob_acc, w_acc, last_beat, last_tile;

  logic [CPF*DW-1:0]        vec_q [NumBeats];
  logic [CPF*DW-1:0]        cur_vec;
  logic signed [DW+WW-1:0]  prod_q [KPF][CPF];
  logic signed [BIAS_DW-1:0] bias_q [KPF];
  logic                     s1_vld_q, s1_first_q;
  logic signed [ACC_W-1:0]  acc_q [KPF];
  logic signed [ACC_W-1:0]  lane_sum [KPF];
  logic signed [ACC_W-1:0]  bias_seed [KPF];
  logic signed [DW-1:0]     pp_res [KPF];
  logic [KPF*DW-1:0]        dout_d, dout_q;
  logic                     dout_en_q, dout_eop_q;

  assign blob_acc  = bus.blob_din_en && blob_rdy;
  assign w_acc     = bus.w_din_en && w_rdy;
  assign last_beat = (beat_q == BeatW'(NumBeats - 1));
  assign last_tile = (tile_q == TileW'(NumTiles - 1));
  assign cur_vec   = vec_q[beat_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      tile_q   <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tile_q   <= tile_d;
      drain_q  <= (state_q == StDrain) ? drain_q + 2'd1 : 2'd0;
      // eop must mark exactly the final input beat.
      err_q    <= err_q | (blob_acc && (bus.blob_din_eop != last_beat));
      s1_vld_q <= w_acc;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tile_d   = tile_q;
    blob_rdy = 1'b0;
    w_rdy    = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      StIdle, StLoad: begin
        blob_rdy = 1'b1;
        if (blob_acc) begin
          if (last_beat) begin
            state_d = StComp;
            beat_d  = '0;
            tile_d  = '0;
          end else begin
            state_d = StLoad;
            beat_d  = beat_q + BeatW'(1);
          end
        end
      end
      StComp: begin
        w_rdy = 1'b1;
        if (w_acc) begin
          if (last_beat) begin
            state_d = StDrain;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StDrain: begin
        // Two cycles let the product and accumulate stages settle.
        if (drain_q == 2'd2) begin
          state_d  = StOut;
          load_out = 1'b1;
        end
      end
      StOut: begin
        if (bus.blob_dout_rdy) begin
          if (last_tile) begin
            state_d = StIdle;
          end else begin
            state_d = StComp;
            tile_d  = tile_q + TileW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (blob_acc) begin
      vec_q[beat_q] <= bus.blob_din;
    end
  end

  // Stage 1: register products and, on the first beat of a tile, the bias.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      s1_first_q <= (beat_q == '0);
      for (int k = 0; k < KPF; k++) begin
        for (int c = 0; c < CPF; c++) begin
          prod_q[k][c] <= (DW+WW)'(signed'(cur_vec[c*DW +: DW])) *
                          (DW+WW)'(signed'(bus.w_din[(k*CPF+c)*WW +: WW]));
        end
        if (beat_q == '0) begin
          bias_q[k] <= signed'(bus.bias_din[k*BIAS_DW +: BIAS_DW]);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      lane_sum[k] = '0;
      for (int c = 0; c < CPF; c++) begin
        lane_sum[k] = lane_sum[k] + ACC_W'(prod_q[k][c]);
      end
      bias_seed[k] = ACC_W'(bias_q[k]) <<< BiasShift;
    end
  end

  // Stage 2: the first beat of a tile replaces the old sum with the aligned bias.
  always_ff @(posedge clk) begin
    if (s1_vld_q) begin
      for (int k = 0; k < KPF; k++) begin
        acc_q[k] <= (s1_first_q ? bias_seed[k] : acc_q[k]) + lane_sum[k];
      end
    end
  end

  for (genvar k = 0; k < KPF; k++) begin : g_pp
    fc_postproc #(
      .ACC_W(ACC_W),
      .DW   (DW),
      .SH   (OutShift),
      .RELU (RELU)
    ) u_pp (
      .acc_i(acc_q[k]),
      .res_o(pp_res[k])
    );
  end

  // Lanes past K_OUT in a partial last tile are forced to zero.
  always_comb begin
    dout_d = '0;
    for (int k = 0; k < KPF; k++) begin
      if (32'(tile_q) * KPF + 32'(k) < K_OUT) begin
        dout_d[k*DW +: DW] = pp_res[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      dout_eop_q <= 1'b0;
    end else if (load_out) begin
      dout_q     <= dout_d;
      dout_en_q  <= 1'b1;
      dout_eop_q <= last_tile;
    end else if (state_q == StOut && bus.blob_dout_rdy) begin
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      dout_eop_q <= 1'b0;
    end
  end

  assign bus.blob_din_rdy  = blob_rdy;
  assign bus.w_din_rdy     = w_rdy;
  assign bus.blob_dout     = dout_q;
  assign bus.blob_dout_en  = dout_en_q;
  assign bus.blob_dout_eop = dout_eop_q;
  assign bus.err           = err_q;

endmodule
